uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter: DATA_W, 8, data bits per frame; legal range 5..9.
REQ-002 Parameter: CLKS_PER_BIT, 16, tx_clk cycles per serial bit; legal range >= 2.
REQ-003 Port: tx_clk  in  1  single clock for the block; all logic on its rising edge.
REQ-004 Port: tx_en  in  1  reset; asynchronous assertion, active-low.
REQ-005 Port: tx_i_data  in  DATA_W  parallel word to transmit.
REQ-006 Port: tx_i_data_valid  in  1  word on tx_i_data is valid.
REQ-007 Port: tx_i_parity  in  2  parity mode: 0 none, 1 even, 2 odd, 3 treated as none.
REQ-008 Port: tx_i_stop2  in  1  1 = two stop bits, 0 = one stop bit.
REQ-009 Port: tx_o_ready  out  1  block accepts a word this cycle.
REQ-010 Port: tx_o_done  out  1  one-cycle pulse at end of last stop bit.
REQ-011 Port: tx_o  out  1  serial line; idle high.

Function
REQ-012 Handshake: a word is accepted on the rising edge where tx_o_ready=1 and tx_i_data_valid=1; tx_i_data, tx_i_parity and tx_i_stop2 are captured on that edge.
REQ-013 tx_o_ready is registered; it is 1 only in IDLE and falls on the acceptance edge; tx_i_data_valid while tx_o_ready=0 is ignored, and input changes after acceptance do not affect the frame in flight.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP; IDLE->START on acceptance; START->DATA after one bit time; DATA->PARITY (parity enabled) or ->STOP after DATA_W bit times; PARITY->STOP after one bit time; STOP->IDLE after one or two bit times.
REQ-015 Bit timing: each bit drives tx_o for exactly CLKS_PER_BIT cycles; the bit counter restarts at every state entry; the first START cycle is the cycle after the acceptance edge.
REQ-016 Line values: IDLE 1; START 0; DATA bits LSB first; PARITY = XOR of captured word (even) or its inverse (odd); STOP 1.
REQ-017 tx_o is driven from a flop; there is no combinational path from any input to tx_o.
REQ-018 tx_o_done pulses high for exactly the one cycle in which STOP->IDLE occurs; tx_o_ready rises on the same edge.
REQ-019 Back-to-back: a word presented while tx_o_ready=1 immediately after tx_o_done is accepted; minimum frame period is (2+DATA_W+P+S)*CLKS_PER_BIT-CLKS_PER_BIT+1 cycles, with P in {0,1} and S in {1,2}.
REQ-020 The bit-time counter is ceil(log2(CLKS_PER_BIT)) bits wide and the data-bit counter ceil(log2(DATA_W+1)) bits wide; neither wraps within a state.

Reset
REQ-021 While tx_en=0: state IDLE, all counters 0, tx_o=1, tx_o_ready=0, tx_o_done=0, captured word 0.
REQ-022 tx_o_ready rises on the first rising edge after tx_en deasserts.
REQ-023 tx_en assertion mid-frame aborts the frame immediately (tx_o=1 asynchronously); no tx_o_done pulse is produced for the aborted frame.

Structure
REQ-024 Package uart_pkg holds the parity mode typedef (PAR_NONE, PAR_EVEN, PAR_ODD) and the tx state enum.
REQ-025 Sub-module uart_baud_gen generates the bit-time counter and a one-cycle bit-end tick, with restart input, CLKS_PER_BIT parameter, and tx_clk/tx_en ports.

Verification
REQ-026 DATA_W=8, CLKS_PER_BIT=4, even parity, 1 stop, send 0xA5 -> tx_o per bit 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles; tx_o_done pulses 44 cycles after the acceptance edge.
REQ-027 Send 0x01 odd parity, then 0x01 even parity -> parity bit 0, then 1.
REQ-028 Parity none, stop2=1, send 0xFF -> no parity bit; line high for 8 cycles after the last data bit; then tx_o_done pulses.
REQ-029 tx_i_data_valid held high with 3 words queued by the bench -> frames are separated by exactly 1 idle cycle; each word is captured once; changing tx_i_data mid-frame does not alter the frame.
REQ-030 Assert tx_en low during DATA bit 3 -> tx_o=1 and tx_o_ready=0 at once, no tx_o_done; after release, tx_o_ready=1 on the first edge and the next 0x3C frame is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: parity modes and the tx state encoding.
package uart_pkg;

  // Parity mode as seen on tx_i_parity. Code 3 has no name and behaves as none.
  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } par_mode_t;

  // Transmit sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // True when the raw mode code asks for a parity bit in the frame.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // True when the raw mode code selects odd parity.
  function automatic logic par_is_odd(input logic [1:0] mode);
    return (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: down-counter reloaded on restart or at terminal count,
// producing a one-cycle tick in the last cycle of every bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic tx_clk,
  input  logic tx_en,
  input  logic restart,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Hold the reload value while restart is high so the first bit after it
  // lasts a full CLKS_PER_BIT cycles; reload at zero so consecutive bits chain.
  always_ff @(posedge tx_clk or negedge tx_en) begin
    if (!tx_en) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == '0)) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // The zero left in the counter by reset must not look like a bit end.
  assign bit_tick = (cnt_q == '0) && !restart;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity, one or two stop bits. All outputs are registered.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, ready high, waiting for a valid word
// ST_START  | line low for one bit time
// ST_DATA   | shifting out captured word, LSB first, DATA_W bit times
// ST_PARITY | parity bit of the captured word for one bit time
// ST_STOP   | line high for one or two bit times, done pulse on exit
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              tx_clk,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] tx_i_data,
  input  logic              tx_i_data_valid,
  input  logic [1:0]        tx_i_parity,
  input  logic              tx_i_stop2,
  output logic              tx_o_ready,
  output logic              tx_o_done,
  output logic              tx_o
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              bit_tick;
  logic              restart;
  logic              accept;

  // The bit timer is held in reload while idle, so the first START cycle
  // (the one after acceptance) begins a full bit time.
  assign restart = (state_q == ST_IDLE);
  assign accept  = ready_q && tx_i_data_valid;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .tx_clk  (tx_clk),
    .tx_en   (tx_en),
    .restart (restart),
    .bit_tick(bit_tick)
  );

  // State and all output registers; reset forces an idle-high line at once.
  always_ff @(posedge tx_clk or negedge tx_en) begin
    if (!tx_en) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      bits_q    <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      bits_q    <= bits_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. The line value is computed for the state being entered
  // so tx_o changes on the same edge as the state register.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    bits_d    = bits_q;
    tx_d      = tx_q;
    ready_d   = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (accept) begin
          state_d   = ST_START;
          shift_d   = tx_i_data;
          par_en_d  = par_enabled(tx_i_parity);
          par_bit_d = (^tx_i_data) ^ par_is_odd(tx_i_parity);
          stop2_d   = tx_i_stop2;
          bits_d    = '0;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          bits_d  = DATA_LAST;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (bits_q == '0) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              bits_d  = BIT_W'(stop2_q);
              tx_d    = 1'b1;
            end
          end else begin
            bits_d  = bits_q - BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          bits_d  = BIT_W'(stop2_q);
          tx_d    = 1'b1;
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          if (bits_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            bits_d = bits_q - BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx_o       = tx_q;
  assign tx_o_ready = ready_q;
  assign tx_o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frames, back-to-back traffic,
// mid-frame reset and randomized frames against a bit-list frame model.
module tb_uart_tx_cfg;

  localparam int DATA_W = 8;
  localparam int C      = 4;

  logic              tx_clk;
  logic              tx_en;
  logic [DATA_W-1:0] tx_i_data;
  logic              tx_i_data_valid;
  logic [1:0]        tx_i_parity;
  logic              tx_i_stop2;
  logic              tx_o_ready;
  logic              tx_o_done;
  logic              tx_o;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_cfg #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(C)
  ) dut (
    .tx_clk         (tx_clk),
    .tx_en          (tx_en),
    .tx_i_data      (tx_i_data),
    .tx_i_data_valid(tx_i_data_valid),
    .tx_i_parity    (tx_i_parity),
    .tx_i_stop2     (tx_i_stop2),
    .tx_o_ready     (tx_o_ready),
    .tx_o_done      (tx_o_done),
    .tx_o           (tx_o)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Wait (bounded) for ready, sampling on falling edges.
  task automatic wait_ready();
    int c = 0;
    while (tx_o_ready !== 1'b1 && c < 200) begin
      @(negedge tx_clk);
      c++;
    end
    if (tx_o_ready !== 1'b1) chk("ready_timeout", {31'd0, tx_o_ready}, 32'd1);
  endtask

  // Frame model: the list of line levels, one entry per bit time.
  function automatic void build_frame(input logic [DATA_W-1:0] w, input logic [1:0] par,
                                      input logic st2, output bit bits[$]);
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(w[i]);
    if (par == 2'd1) bits.push_back(^w);
    if (par == 2'd2) bits.push_back(~^w);
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
  endfunction

  // Present one word, then check every cycle of its frame plus the done cycle.
  // Inputs are scrambled after acceptance; hold_valid keeps valid high.
  task automatic send_frame(input logic [DATA_W-1:0] w, input logic [1:0] par,
                            input logic st2, input bit hold_valid);
    bit exp_bits[$];
    int n;
    wait_ready();
    tx_i_data       = w;
    tx_i_parity     = par;
    tx_i_stop2      = st2;
    tx_i_data_valid = 1'b1;
    @(posedge tx_clk);
    #1;
    tx_i_data   = DATA_W'($urandom);
    tx_i_parity = 2'($urandom);
    tx_i_stop2  = 1'($urandom);
    if (!hold_valid) tx_i_data_valid = 1'b0;
    build_frame(w, par, st2, exp_bits);
    n = exp_bits.size() * C;
    for (int k = 0; k < n; k++) begin
      @(negedge tx_clk);
      chk($sformatf("tx_o w=%0h bit%0d", w, k / C), {31'd0, tx_o}, {31'd0, exp_bits[k / C]});
      chk("done_low", {31'd0, tx_o_done}, 32'd0);
      chk("ready_low", {31'd0, tx_o_ready}, 32'd0);
    end
    @(negedge tx_clk);
    chk("done_pulse", {31'd0, tx_o_done}, 32'd1);
    chk("ready_after_done", {31'd0, tx_o_ready}, 32'd1);
    chk("line_idle", {31'd0, tx_o}, 32'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    logic [1:0]        p;
    logic              s;
    bit                h;

    tx_en           = 1'b0;
    tx_i_data       = '0;
    tx_i_data_valid = 1'b0;
    tx_i_parity     = 2'd0;
    tx_i_stop2      = 1'b0;

    repeat (3) @(negedge tx_clk);
    chk("rst_tx_o", {31'd0, tx_o}, 32'd1);
    chk("rst_ready", {31'd0, tx_o_ready}, 32'd0);
    chk("rst_done", {31'd0, tx_o_done}, 32'd0);
    tx_en = 1'b1;
    @(negedge tx_clk);
    chk("ready_first_edge", {31'd0, tx_o_ready}, 32'd1);

    // Directed frames.
    send_frame(8'hA5, 2'd1, 1'b0, 1'b0);
    send_frame(8'h01, 2'd2, 1'b0, 1'b0);
    send_frame(8'h01, 2'd1, 1'b0, 1'b0);
    send_frame(8'hFF, 2'd0, 1'b1, 1'b0);
    send_frame(8'h5A, 2'd3, 1'b0, 1'b0);

    // Three words offered with valid held high: one idle cycle between frames.
    send_frame(8'h12, 2'd1, 1'b0, 1'b1);
    send_frame(8'h34, 2'd2, 1'b1, 1'b1);
    send_frame(8'h56, 2'd0, 1'b0, 1'b0);
    @(negedge tx_clk);
    chk("no_extra_frame", {31'd0, tx_o}, 32'd1);
    chk("no_extra_done", {31'd0, tx_o_done}, 32'd0);

    // Abort during data bit 3 of an all-zero word.
    wait_ready();
    tx_i_data       = 8'h00;
    tx_i_parity     = 2'd1;
    tx_i_stop2      = 1'b0;
    tx_i_data_valid = 1'b1;
    @(posedge tx_clk);
    #1;
    tx_i_data_valid = 1'b0;
    repeat (4 * C + 2) @(negedge tx_clk);
    chk("pre_abort_line", {31'd0, tx_o}, 32'd0);
    tx_en = 1'b0;
    #1;
    chk("abort_tx_o", {31'd0, tx_o}, 32'd1);
    chk("abort_ready", {31'd0, tx_o_ready}, 32'd0);
    chk("abort_done", {31'd0, tx_o_done}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge tx_clk);
      chk("abort_hold_done", {31'd0, tx_o_done}, 32'd0);
      chk("abort_hold_tx_o", {31'd0, tx_o}, 32'd1);
    end
    tx_en = 1'b1;
    @(negedge tx_clk);
    chk("ready_after_abort", {31'd0, tx_o_ready}, 32'd1);
    chk("done_after_abort", {31'd0, tx_o_done}, 32'd0);
    send_frame(8'h3C, 2'd1, 1'b0, 1'b0);

    // Randomized frames, mixing back-to-back and idle gaps.
    for (int f = 0; f < 14; f++) begin
      w = DATA_W'($urandom);
      p = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 1) == 1) && (f != 13);
      send_frame(w, p, s, h);
      if (!h) repeat ($urandom_range(0, 3)) @(negedge tx_clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so a stuck design still reaches a verdict.
  initial begin
    #400000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
